mult_adder_engine: RTL and testbench
====================================

// Module: mult_adder_engine
// PURPOSE
// - Responder side of the fully-connected layer's MultAdder interface: computes the dot product of two
//   128-lane vectors of 8-bit sign-magnitude values and returns a 15-bit sign-magnitude sum plus overflow.
// - Sits between the FC layer sequencers (initiators) and the Float8Adder datapath format. It processes
//   LPC lanes per cycle with an explicit start/busy/done handshake instead of one combinational tree.
// PARAMETERS
// - LANES  128  lanes per operand vector; must be a multiple of LPC
// - LPC    8    lanes multiplied and accumulated per clock
// - DATA_W 8    lane width: bit7 sign, bits6:0 magnitude Q0.7
// - SUM_W  15   result width: bit14 sign, bits13:0 magnitude Q0.14
// - ACC_W  22   internal two's-complement accumulator width; must be >= 14+log2(LANES)+1
// PORTS
// - clk        in   1                 clock, rising edge
// - iRst_n     in   1                 reset: synchronous, active-low
// - iStart     in   1                 request; sampled only in IDLE
// - iOpr1      in   LANES*DATA_W      activation vector; lane k = bits [8k+7 -: 8]
// - iOpr2      in   LANES*DATA_W      weight vector, same lane layout
// - oBusy      out  1                 high in ACCUM and FINAL
// - oDone      out  1                 one-cycle pulse; result valid
// - oSum       out  SUM_W             sign-magnitude dot product, held until next oDone
// - oOverflow  out  1                 result magnitude exceeded 14'h3FFF; held with oSum
// BEHAVIOUR
// - Reset (iRst_n=0 at an edge): state=IDLE, acc=0, lane index=0, oBusy=0, oDone=0, oSum=0, oOverflow=0.
//   Reset mid-operation aborts the computation. No oDone is produced for the aborted request.
// - States: IDLE -> ACCUM -> FINAL -> IDLE.
// - IDLE: if iStart=1, latch iOpr1/iOpr2 into internal registers, clear acc and index, go to ACCUM.
//   Operand inputs are don't-care after the start edge.
// - ACCUM: lanes idx*LPC .. idx*LPC+LPC-1 are processed in one cycle.
//   - Per-lane product magnitude = mag1*mag2 (7x7 -> 14 bits, Q0.14).
//   - Product sign = s1^s2; a zero-magnitude product contributes 0 regardless of sign.
//   - The signed products are summed and added to acc in two's complement, with no intermediate saturation.
//   - idx increments each cycle. After group LANES/LPC-1, go to FINAL.
// - FINAL: convert acc to sign-magnitude.
//   - If |acc| > 16383: oSum = {sign, 14'h3FFF}, oOverflow=1.
//   - Otherwise oSum = {sign, |acc|[13:0]}, oOverflow=0.
//   - A zero result always has sign 0.
//   - Set oDone=1 for exactly one cycle and go to IDLE.
// - Latency: with iStart sampled at edge E0, oDone is high during the cycle after edge E0+LANES/LPC+1
//   (E17 with default parameters). Throughput is one request per LANES/LPC+2 cycles.
// - iStart while oBusy=1 is ignored: not queued, no effect.
// - iStart during the oDone cycle is accepted, because the block is already in IDLE.
// - oSum and oOverflow change only at the FINAL edge or on reset.
// - oOverflow reflects only the current request. Accumulation across requests is the initiator's job.
// TESTING
// - All lanes 0x00, start -> oDone at E0+17, oSum=15'h0000, oOverflow=0.
// - Lane0 opr1=0x40, opr2=0x40, all other lanes 0 -> oSum=15'h1000, oOverflow=0.
// - Lane0 0xC0*0x40 -> oSum=15'h5000.
// - Cancellation: lane0 0x40*0x40 and lane1 0xC0*0x40 -> oSum=15'h0000, sign 0.
// - All lanes 0x7F*0x7F (sum 2064512) -> oSum=15'h3FFF, oOverflow=1.
//   A following request with a single 0x40*0x40 lane -> oOverflow=0, oSum=15'h1000.
// - Start, then re-pulse iStart at E0+5 with different operands, then assert iRst_n=0 at E0+10 in a
//   second run:
//   - The re-pulse is ignored; the first run completes with the original operands.
//   - The reset run produces no oDone, and all outputs return to 0.

Source files
------------

// File: rtl/mult_adder_engine.sv
// rtl/mult_adder_engine.sv - sign-magnitude 8-bit dot-product engine, LPC lanes per clock
module mult_adder_engine #(
  parameter int LANES  = 128,
  parameter int LPC    = 8,
  parameter int DATA_W = 8,
  parameter int SUM_W  = 15,
  parameter int ACC_W  = 22
) (
  input  logic                      clk,
  input  logic                      iRst_n,
  input  logic                      iStart,
  input  logic [LANES*DATA_W-1:0]   iOpr1,
  input  logic [LANES*DATA_W-1:0]   iOpr2,
  output logic                      oBusy,
  output logic                      oDone,
  output logic [SUM_W-1:0]          oSum,
  output logic                      oOverflow
);

  localparam int GROUPS = LANES / LPC;
  localparam int IDX_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int MAG_W  = DATA_W - 1;
  localparam int PROD_W = 2 * MAG_W;
  localparam int MAG_O  = SUM_W - 1;
  localparam int GRP_W  = LPC * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINAL} state_t;

  state_t                  state, next_state;
  logic [LANES*DATA_W-1:0] opr1_q, opr2_q;
  logic [ACC_W-1:0]        acc;
  logic [IDX_W-1:0]        idx;
  logic [ACC_W-1:0]        group_sum;
  logic [ACC_W-1:0]        acc_abs;
  logic                    acc_ovf;
  logic                    load, accum_en, final_en;

  function automatic logic [ACC_W-1:0] lane_term(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [PROD_W-1:0] p;
    logic [ACC_W-1:0]  ext;
    p   = PROD_W'(a[MAG_W-1:0]) * PROD_W'(b[MAG_W-1:0]);
    ext = {{(ACC_W-PROD_W){1'b0}}, p};
    return (a[DATA_W-1] ^ b[DATA_W-1]) ? -ext : ext;
  endfunction

  // Operand registers shift right one group per cycle, so the low GRP_W bits are always the current group.
  always_comb begin
    group_sum = '0;
    for (int j = 0; j < LPC; j++) begin
      group_sum = group_sum + lane_term(opr1_q[j*DATA_W +: DATA_W], opr2_q[j*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    acc_abs = acc[ACC_W-1] ? -acc : acc;
    acc_ovf = |acc_abs[ACC_W-1:MAG_O];
  end

  always_ff @(posedge clk) begin
    if (!iRst_n) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (iStart) next_state = S_ACCUM;
      S_ACCUM: if (idx == IDX_W'(GROUPS - 1)) next_state = S_FINAL;
      S_FINAL: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    oBusy    = 1'b0;
    load     = 1'b0;
    accum_en = 1'b0;
    final_en = 1'b0;
    case (state)
      S_IDLE:  load = iStart;
      S_ACCUM: begin oBusy = 1'b1; accum_en = 1'b1; end
      S_FINAL: begin oBusy = 1'b1; final_en = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      opr1_q    <= '0;
      opr2_q    <= '0;
      acc       <= '0;
      idx       <= '0;
      oDone     <= 1'b0;
      oSum      <= '0;
      oOverflow <= 1'b0;
    end else begin
      oDone <= final_en;
      if (load) begin
        opr1_q <= iOpr1;
        opr2_q <= iOpr2;
        acc    <= '0;
        idx    <= '0;
      end else if (accum_en) begin
        opr1_q <= opr1_q >> GRP_W;
        opr2_q <= opr2_q >> GRP_W;
        acc    <= acc + group_sum;
        idx    <= idx + 1'b1;
      end
      // A zero accumulator has a clear sign bit, so zero never comes out negative.
      if (final_en) begin
        oOverflow <= acc_ovf;
        oSum      <= {acc[ACC_W-1], acc_ovf ? {MAG_O{1'b1}} : acc_abs[MAG_O-1:0]};
      end
    end
  end

endmodule

// File: tb/tb_mult_adder_engine.sv
// tb/tb_mult_adder_engine.sv - directed-vector bench for mult_adder_engine
module tb_mult_adder_engine;

  logic          clk = 1'b0;
  logic          iRst_n, iStart;
  logic [1023:0] iOpr1, iOpr2;
  logic          oBusy, oDone, oOverflow;
  logic [14:0]   oSum;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  mult_adder_engine dut (
    .clk(clk), .iRst_n(iRst_n), .iStart(iStart), .iOpr1(iOpr1), .iOpr2(iOpr2),
    .oBusy(oBusy), .oDone(oDone), .oSum(oSum), .oOverflow(oOverflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_ops;
    iOpr1 = '0;
    iOpr2 = '0;
  endtask

  task automatic set_lane(input int k, input logic [7:0] a, input logic [7:0] b);
    iOpr1[8*k +: 8] = a;
    iOpr2[8*k +: 8] = b;
  endtask

  task automatic scramble_ops;
    for (int k = 0; k < 32; k++) begin
      iOpr1[32*k +: 32] = $urandom();
      iOpr2[32*k +: 32] = $urandom();
    end
  endtask

  // Returns at #1 after the start edge (E0).
  task automatic pulse_start;
    iStart = 1'b1;
    @(posedge clk);
    #1;
    iStart = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (oDone) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (oDone) cnt++;
    end
  endtask

  task automatic run(input string tag, input logic [14:0] esum, input logic eov);
    int n;
    pulse_start();
    chk({tag, "_busy"}, oBusy, 1);
    chk({tag, "_nodone"}, oDone, 0);
    scramble_ops();
    wait_done(n);
    chk({tag, "_lat"}, n, 17);
    chk({tag, "_sum"}, oSum, esum);
    chk({tag, "_ovf"}, oOverflow, eov);
  endtask

  initial begin
    int n, cnt;
    iRst_n = 1'b0;
    iStart = 1'b0;
    clear_ops();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_sum", oSum, 0);
    chk("rst_ovf", oOverflow, 0);
    iRst_n = 1'b1;

    clear_ops();
    run("zero", 15'h0000, 1'b0);

    clear_ops(); set_lane(0, 8'h40, 8'h40);
    run("half", 15'h1000, 1'b0);

    clear_ops(); set_lane(0, 8'hC0, 8'h40);
    run("neg", 15'h5000, 1'b0);

    clear_ops(); set_lane(0, 8'h40, 8'h40); set_lane(1, 8'hC0, 8'h40);
    run("cancel", 15'h0000, 1'b0);

    clear_ops();
    for (int k = 0; k < 128; k++) set_lane(k, 8'h7F, 8'h7F);
    run("sat", 15'h3FFF, 1'b1);

    clear_ops(); set_lane(0, 8'h40, 8'h40);
    run("after_sat", 15'h1000, 1'b0);

    // 16129 + 254 = 16383 exactly
    clear_ops(); set_lane(0, 8'h7F, 8'h7F); set_lane(1, 8'h7F, 8'h02);
    run("max", 15'h3FFF, 1'b0);

    // 16129 + 255 = 16384
    clear_ops(); set_lane(0, 8'h7F, 8'h7F); set_lane(1, 8'h0F, 8'h11);
    run("max_p1", 15'h3FFF, 1'b1);

    clear_ops();
    for (int k = 0; k < 128; k++) set_lane(k, 8'hFF, 8'h7F);
    run("neg_sat", 15'h7FFF, 1'b1);

    // 1024 - 127 = 897; lane 50 is a negative zero
    clear_ops(); set_lane(9, 8'h20, 8'h20); set_lane(127, 8'h7F, 8'h81); set_lane(50, 8'h80, 8'hFF);
    run("far", 15'h0381, 1'b0);

    clear_ops(); set_lane(0, 8'h40, 8'h40);
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 128; k++) set_lane(k, 8'h7F, 8'h7F);
    iStart = 1'b1;
    @(posedge clk);
    #1;
    iStart = 1'b0;
    chk("repulse_busy", oBusy, 1);
    wait_done(n);
    chk("repulse_lat", n, 12);
    chk("repulse_sum", oSum, 15'h1000);
    chk("repulse_ovf", oOverflow, 0);
    count_done(20, cnt);
    chk("repulse_extra", cnt, 0);

    clear_ops(); set_lane(0, 8'hC0, 8'h40);
    pulse_start();
    repeat (9) @(posedge clk);
    #1;
    iRst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", oBusy, 0);
    chk("abort_done", oDone, 0);
    chk("abort_sum", oSum, 0);
    chk("abort_ovf", oOverflow, 0);
    iRst_n = 1'b1;
    count_done(25, cnt);
    chk("abort_nodone", cnt, 0);
    chk("abort_idle", oBusy, 0);

    clear_ops(); set_lane(3, 8'hC0, 8'h40);
    run("post_rst", 15'h5000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
